// File: rtl/mem_bus_arbiter_if.sv
// Bus between the per-core cache controllers and the shared memory-port arbiter.
interface mem_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               busy;
  logic               timeout;
  logic [IDW-1:0]     timeout_id;

  // Requester side: raises requests, observes grants
  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout, timeout_id
  );

  // Arbiter side
  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout, timeout_id
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory port: one owner at a time, tenure
// bounded by MAX_HOLD cycles, one idle turnaround cycle between tenures.
module mem_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(MAX_HOLD + 1);

  typedef logic [IDW-1:0] id_t;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t             state_q, state_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  id_t                id_q, id_n;
  id_t                ptr_q, ptr_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic               busy_q, busy_n;
  logic               to_q, to_n;
  id_t                toid_q, toid_n;

  id_t         win;
  id_t         sel;
  logic        found;
  logic        any_req;
  int unsigned idx;
  logic        limit;
  logic        owner_done;
  logic        owner_req;

  // Winner = first set req bit scanning upward from the rr pointer with wrap
  always_comb begin
    any_req = |bus.req;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      sel = id_t'(idx);
      if (!found && bus.req[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_n    = state_q;
    gnt_n      = gnt_q;
    id_n       = id_q;
    ptr_n      = ptr_q;
    cnt_n      = cnt_q;
    to_n       = 1'b0;
    toid_n     = toid_q;
    limit      = (cnt_q == CW'(MAX_HOLD));
    owner_done = bus.done[id_q];
    owner_req  = bus.req[id_q];
    case (state_q)
      IDLE, RELEASE: begin
        if (any_req) begin
          state_n = GRANT;
          gnt_n   = ONE_HOT0 << win;
          id_n    = win;
          cnt_n   = CW'(1);
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          id_n    = '0;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (owner_done || !owner_req || limit) begin
          state_n = RELEASE;
          gnt_n   = '0;
          id_n    = '0;
          cnt_n   = '0;
          ptr_n   = (id_q == id_t'(NUM_REQ - 1)) ? '0 : id_q + id_t'(1);
          // Only a tenure that ran out the clock with the owner still asking
          // counts as a timeout; done/req-drop on the limit cycle is normal.
          if (limit && !owner_done && owner_req) begin
            to_n   = 1'b1;
            toid_n = id_q;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        id_n    = '0;
        cnt_n   = '0;
      end
    endcase
    busy_n = |gnt_n;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      toid_q  <= '0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      id_q    <= id_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      busy_q  <= busy_n;
      to_q    <= to_n;
      toid_q  <= toid_n;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_id     = id_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = to_q;
  assign bus.timeout_id = toid_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (NUM_REQ=4, MAX_HOLD=16).
module tb_mem_bus_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_bus_arbiter_if #(.NUM_REQ(4)) bus_if ();

  mem_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may be changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req  = '0;
    bus_if.done = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 5;
    if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", bus_if.gnt); end
    if (bus_if.gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id got=%0d exp=0", bus_if.gnt_id); end
    if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    if (bus_if.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", bus_if.timeout); end
    if (bus_if.timeout_id !== 2'd0) begin n_fail++; $display("FAIL reset_timeout_id got=%0d exp=0", bus_if.timeout_id); end
  endtask

  task automatic test_single();
    do_reset();
    tick();
    bus_if.req = 4'b0100;
    tick();
    n_checks += 3;
    if (bus_if.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", bus_if.gnt); end
    if (bus_if.gnt_id !== 2'd2) begin n_fail++; $display("FAIL single_gnt_id got=%0d exp=2", bus_if.gnt_id); end
    if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", bus_if.busy); end
    tick();
    tick();
    bus_if.done = 4'b0100;
    bus_if.req  = 4'b0000;
    tick();
    bus_if.done = 4'b0000;
    n_checks += 3;
    if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_release_gnt got=%b exp=0000", bus_if.gnt); end
    if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL single_release_busy got=%b exp=0", bus_if.busy); end
    if (bus_if.timeout !== 1'b0) begin n_fail++; $display("FAIL single_release_timeout got=%b exp=0", bus_if.timeout); end
    tick();
    n_checks++;
    if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt got=%b exp=0000", bus_if.gnt); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_gnt;
    do_reset();
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << exp_order[k];
      for (int c = 1; c <= 3; c++) begin
        tick();
        n_checks++;
        if (bus_if.gnt !== exp_gnt || bus_if.gnt_id !== 2'(exp_order[k])) begin
          n_fail++;
          $display("FAIL rr_grant%0d_cycle%0d got=%b/%0d exp=%b/%0d", k, c, bus_if.gnt, bus_if.gnt_id, exp_gnt, exp_order[k]);
        end
      end
      bus_if.done = exp_gnt;
      if (k == 4) bus_if.req = 4'b0000;
      tick();
      bus_if.done = 4'b0000;
      n_checks++;
      if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_gap%0d got=%b exp=0000", k, bus_if.gnt); end
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    bus_if.req = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_checks++;
      if (bus_if.gnt !== 4'b0001 || bus_if.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold_cycle%0d got gnt=%b timeout=%b exp gnt=0001 timeout=0", c, bus_if.gnt, bus_if.timeout);
      end
    end
    tick();
    n_checks += 3;
    if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL to_release_gnt got=%b exp=0000", bus_if.gnt); end
    if (bus_if.timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse got=%b exp=1", bus_if.timeout); end
    if (bus_if.timeout_id !== 2'd0) begin n_fail++; $display("FAIL to_id got=%0d exp=0", bus_if.timeout_id); end
    tick();
    n_checks += 2;
    if (bus_if.gnt !== 4'b0001) begin n_fail++; $display("FAIL to_regrant got=%b exp=0001", bus_if.gnt); end
    if (bus_if.timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width got=%b exp=0", bus_if.timeout); end
    bus_if.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_non_owner_done();
    do_reset();
    bus_if.req = 4'b0010;
    tick();
    n_checks++;
    if (bus_if.gnt !== 4'b0010) begin n_fail++; $display("FAIL nod_grant got=%b exp=0010", bus_if.gnt); end
    bus_if.done = 4'b1000;
    tick();
    bus_if.done = 4'b0000;
    n_checks += 2;
    if (bus_if.gnt !== 4'b0010) begin n_fail++; $display("FAIL nod_hold got=%b exp=0010", bus_if.gnt); end
    if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL nod_busy got=%b exp=1", bus_if.busy); end
    tick();
    n_checks++;
    if (bus_if.gnt !== 4'b0010) begin n_fail++; $display("FAIL nod_hold2 got=%b exp=0010", bus_if.gnt); end
    bus_if.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_if.req = 4'b1000;
    for (int c = 0; c < 5; c++) tick();
    n_checks++;
    if (bus_if.gnt !== 4'b1000) begin n_fail++; $display("FAIL rmid_owner got=%b exp=1000", bus_if.gnt); end
    bus_if.req = 4'b1001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks += 4;
    if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL rmid_gnt got=%b exp=0000", bus_if.gnt); end
    if (bus_if.gnt_id !== 2'd0) begin n_fail++; $display("FAIL rmid_gnt_id got=%0d exp=0", bus_if.gnt_id); end
    if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", bus_if.busy); end
    if (bus_if.timeout !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout got=%b exp=0", bus_if.timeout); end
    tick();
    n_checks += 2;
    if (bus_if.gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_regrant got=%b exp=0001", bus_if.gnt); end
    if (bus_if.gnt_id !== 2'd0) begin n_fail++; $display("FAIL rmid_regrant_id got=%0d exp=0", bus_if.gnt_id); end
    bus_if.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_done_on_limit();
    do_reset();
    bus_if.req = 4'b0100;
    tick();
    for (int c = 0; c < 15; c++) tick();
    n_checks++;
    if (bus_if.gnt !== 4'b0100) begin n_fail++; $display("FAIL lim_cycle16_gnt got=%b exp=0100", bus_if.gnt); end
    bus_if.done = 4'b0100;
    tick();
    bus_if.done = 4'b0000;
    n_checks += 2;
    if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL lim_release_gnt got=%b exp=0000", bus_if.gnt); end
    if (bus_if.timeout !== 1'b0) begin n_fail++; $display("FAIL lim_timeout got=%b exp=0", bus_if.timeout); end
    tick();
    n_checks++;
    if (bus_if.gnt !== 4'b0100) begin n_fail++; $display("FAIL lim_regrant got=%b exp=0100", bus_if.gnt); end
    bus_if.req = 4'b0000;
    tick();
    tick();
  endtask

  // New request arriving with the release edge is served from the advanced pointer
  task automatic test_back_to_back();
    do_reset();
    bus_if.req = 4'b0101;
    tick();
    n_checks++;
    if (bus_if.gnt !== 4'b0001) begin n_fail++; $display("FAIL b2b_first got=%b exp=0001", bus_if.gnt); end
    bus_if.done = 4'b0001;
    bus_if.req  = 4'b0111;
    tick();
    bus_if.done = 4'b0000;
    n_checks++;
    if (bus_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL b2b_gap got=%b exp=0000", bus_if.gnt); end
    tick();
    n_checks += 2;
    if (bus_if.gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_second got=%b exp=0010", bus_if.gnt); end
    if (bus_if.gnt_id !== 2'd1) begin n_fail++; $display("FAIL b2b_second_id got=%0d exp=1", bus_if.gnt_id); end
    bus_if.req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus_if.req  = '0;
    bus_if.done = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_non_owner_done();
    test_reset_mid();
    test_done_on_limit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
